// File: rtl/fe_pkg.sv
// Shared constants and types for GF(2^255-19) field blocks.
package fe_pkg;

    localparam int unsigned W       = 17;
    localparam int unsigned N       = 15;
    localparam int unsigned FE_BITS = W * N;

    // Edges from femul sampling start to raising done.
    localparam int unsigned MUL_LAT = 1;

    localparam logic [255:0]         P_EXT    = (256'd1 << 255) - 256'd19;
    localparam logic [FE_BITS-1:0]   P        = P_EXT[FE_BITS-1:0];
    localparam logic [FE_BITS-1:0]   EXP_INV  = P - FE_BITS'(2);
    localparam logic [FE_BITS-1:0]   EXP_SQRT = FE_BITS'((P_EXT + 256'd3) >> 3);

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } fe_state_e;

    typedef enum logic {
        OP_SQ,
        OP_MUL
    } fe_op_e;

endpackage

// File: rtl/femul.sv
// Two-stage modular multiplier mod 2^255-19: product register, then fold-and-reduce register.
// Carries no reset; a consumer must discard done pulses that predate its own reset.
module femul
    import fe_pkg::*;
(
    input  logic               clock,
    input  logic               start,
    input  logic [FE_BITS-1:0] a_in,
    input  logic [FE_BITS-1:0] b_in,
    output logic               ready,
    output logic               done,
    output logic [FE_BITS-1:0] out
);

    localparam int unsigned PW  = 2 * FE_BITS;
    localparam int unsigned T1W = FE_BITS + 5;
    localparam int unsigned T2W = FE_BITS + 1;
    localparam int unsigned SW  = FE_BITS + 2;

    logic               v1_q;
    logic               ready_q;
    logic               done_q;
    logic [PW-1:0]      prod_q;
    logic [FE_BITS-1:0] out_q;

    logic [T1W-1:0]     fold1_c;
    logic [T2W-1:0]     fold2_c;
    logic [SW-1:0]      sub_c;
    logic [FE_BITS-1:0] red_c;

    always_ff @(posedge clock) begin
        v1_q    <= start;
        done_q  <= v1_q;
        ready_q <= ~start & ~v1_q;
        if (start) begin
            prod_q <= PW'(a_in) * PW'(b_in);
        end
        if (v1_q) begin
            out_q <= red_c;
        end
    end

    // 2^255 == 19 (mod p): fold twice, then at most one subtraction of p.
    always_comb begin
        fold1_c = T1W'(prod_q[FE_BITS-1:0]) + T1W'(prod_q[PW-1:FE_BITS]) * T1W'(19);
        fold2_c = T2W'(fold1_c[FE_BITS-1:0]) + T2W'(fold1_c[T1W-1:FE_BITS]) * T2W'(19);
        sub_c   = SW'(fold2_c) - SW'(P);
        red_c   = sub_c[SW-1] ? fold2_c[FE_BITS-1:0] : sub_c[FE_BITS-1:0];
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign out   = out_q;

endmodule

// File: rtl/feinv.sv
// Field exponentiation x^EXP mod p (default: inversion) by left-to-right
// square-and-multiply, sequencing every operation through one femul.
module feinv
    import fe_pkg::*;
#(
    parameter int unsigned      EBITS = 255,
    parameter logic [EBITS-1:0] EXP   = EBITS'(EXP_INV),
    parameter int unsigned      FLUSH = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [FE_BITS-1:0] x_in,
    output logic               ready,
    output logic               done,
    output logic [FE_BITS-1:0] out
);

    localparam int unsigned   IW      = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam int unsigned   CW      = (FLUSH > 1) ? $clog2(FLUSH) : 1;
    localparam logic [IW-1:0] I_START = IW'((EBITS > 1) ? EBITS - 2 : 0);

    fe_state_e          state_q, state_d;
    fe_op_e             op_q, op_d;
    logic [FE_BITS-1:0] x_q, x_d;
    logic [FE_BITS-1:0] r_q, r_d;
    logic [FE_BITS-1:0] out_q, out_d;
    logic [IW-1:0]      i_q, i_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               fin_q, fin_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic               mul_start_c;
    logic [FE_BITS-1:0] mul_b_c;
    logic               mul_done;
    logic [FE_BITS-1:0] mul_out;
    logic               mul_ready_unused;

    femul mul (
        .clock (clock),
        .start (mul_start_c),
        .a_in  (r_q),
        .b_in  (mul_b_c),
        .ready (mul_ready_unused),
        .done  (mul_done),
        .out   (mul_out)
    );

    assign mul_b_c = (op_q == OP_MUL) ? x_q : r_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FLUSH;
            op_q    <= OP_SQ;
            x_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            r_q     <= r_d;
            out_q   <= out_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // A pending finish is parked in ISSUE so the result leaves one edge after the last capture.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        r_d         = r_q;
        out_d       = out_q;
        i_d         = i_q;
        cnt_d       = cnt_q;
        fin_d       = fin_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        mul_start_c = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                if (cnt_q == CW'(FLUSH - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    r_d     = x_in;
                    i_d     = I_START;
                    op_d    = OP_SQ;
                    fin_d   = (EBITS == 32'd1);
                    ready_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fin_q) begin
                    out_d   = r_q;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    fin_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    mul_start_c = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_done) begin
                    r_d     = mul_out;
                    state_d = ST_ISSUE;
                    if (op_q == OP_SQ && EXP[i_q]) begin
                        op_d = OP_MUL;
                    end else if (i_q == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        i_d  = i_q - IW'(1);
                        op_d = OP_SQ;
                    end
                end
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign out   = out_q;

endmodule

// File: tb/tb_feinv.sv
// Scoreboard bench for feinv: stimulus pushes expected results, a negedge monitor pops on done.
module tb_feinv;

    localparam logic [255:0] PM_EXT    = (256'd1 << 255) - 256'd19;
    localparam logic [254:0] PM        = PM_EXT[254:0];
    localparam int           FLUSH_CYC = 64;
    localparam int           NOPS      = 506;
    localparam int           LAT       = NOPS * (int'(fe_pkg::MUL_LAT) + 2) + 1;
    localparam int           NRAND     = 20;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [254:0] x_in;
    logic         ready;
    logic         done;
    logic [254:0] out;

    typedef struct {
        logic [254:0] x;
        logic [254:0] ex;
        bit           prop;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    feinv dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .x_in    (x_in),
        .ready   (ready),
        .done    (done),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [254:0] mmul(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] t;
        t = 510'(a) * 510'(b);
        return 255'(t % 510'(PM));
    endfunction

    // Fermat inverse, right-to-left binary exponentiation over plain modular products.
    function automatic logic [254:0] finv(input logic [254:0] x);
        logic [254:0] base, acc, e;
        base = x % PM;
        acc  = 255'd1;
        e    = PM - 255'd2;
        for (int k = 0; k < 255; k++) begin
            if (e[k]) acc = mmul(acc, base);
            base = mmul(base, base);
        end
        return acc;
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return w[254:0];
    endfunction

    task automatic chk(input string name, input logic [254:0] got, input logic [254:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic start_now(input logic [254:0] x, input logic [254:0] ex, input bit prop);
        sb.push_back('{x: x, ex: ex, prop: prop});
        start = 1'b1;
        x_in  = x;
        @(posedge clock); #1;
        start = 1'b0;
        x_in  = rand255();
    endtask

    task automatic issue(input logic [254:0] x, input logic [254:0] ex, input bit prop);
        int n;
        n = 0;
        while (!ready && n < LAT + 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ready_before_start", 255'(ready), 255'(1));
        start_now(x, ex, prop);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
        end while (!done && cyc < LAT + 200);
        chk("done_seen", 255'(done), 255'(1));
        chk("ready_with_done", 255'(ready), 255'(1));
    endtask

    task automatic flush_check();
        int n;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!ready && n < FLUSH_CYC + 20);
        chk("flush_cycles", 255'(n), 255'(FLUSH_CYC));
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done got=%h want=no_result", out);
            end else begin
                e = sb.pop_front();
                chk("result", out, e.ex);
                if (e.prop && (e.x % PM) != '0) begin
                    chk("inverse_property", mmul(e.x, out), 255'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int           cyc;
        int           bad;
        logic [254:0] xr;
        logic [256:0] t3;

        reset_n = 1'b0;
        start   = 1'b0;
        x_in    = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ready", 255'(ready), 255'(0));
        chk("reset_done", 255'(done), 255'(0));
        chk("reset_out", out, 255'(0));
        reset_n = 1'b1;
        flush_check();

        issue(255'd1, 255'd1, 1'b0);
        wait_done(cyc);
        chk("latency_x1", 255'(cyc), 255'(LAT));

        issue(255'd2, 255'((PM_EXT + 256'd1) >> 1), 1'b0);
        wait_done(cyc);

        issue(PM - 255'd1, PM - 255'd1, 1'b0);
        wait_done(cyc);

        issue(255'd0, 255'd0, 1'b0);
        wait_done(cyc);

        // back-to-back: next start asserted in the done cycle
        xr = rand255();
        issue(xr, finv(xr), 1'b1);
        for (int k = 1; k < NRAND; k++) begin
            wait_done(cyc);
            chk("latency_b2b", 255'(cyc), 255'(LAT));
            xr = rand255();
            start_now(xr, finv(xr), 1'b1);
        end
        wait_done(cyc);

        // start pulses while busy must be ignored
        issue(255'd5, finv(255'd5), 1'b0);
        bad = 0;
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
            if (!done) begin
                if (ready) bad++;
                start = 1'($urandom_range(0, 1));
                x_in  = rand255();
            end
        end while (!done && cyc < LAT + 200);
        start = 1'b0;
        chk("ready_low_while_busy", 255'(bad), 255'(0));
        chk("latency_ignore", 255'(cyc), 255'(LAT));

        // reset 100 cycles into an operation
        issue(255'd7, finv(255'd7), 1'b0);
        repeat (100) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_ready", 255'(ready), 255'(0));
        chk("midreset_done", 255'(done), 255'(0));
        chk("midreset_out", out, 255'(0));
        sb.delete();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        flush_check();

        t3 = (257'(PM) * 257'd2 + 257'd1) / 257'd3;
        issue(255'd3, t3[254:0], 1'b0);
        wait_done(cyc);
        chk("latency_x3", 255'(cyc), 255'(LAT));

        repeat (50) @(posedge clock);
        #1;
        chk("scoreboard_empty", 255'(sb.size()), 255'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
